serial_add_arbiter: RTL

Bit-serial adder controller that shares a single full-adder cell between two requesters. It arbitrates round-robin, captures the winner's operands and steps them LSB-first through one full adder (two half adders plus OR) over WIDTH cycles, carrying through a flip-flop. It then presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between two client blocks and the shared arithmetic slice, trading latency for area.

---
 rtl/serial_add_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/serial_add_arbiter.sv
//------------------------------------------------------------------------------
// serial_add_arbiter
//
// Two requesters share one full-adder cell. Round-robin arbitration picks a
// requester. The winner's operands are captured and added LSB-first over WIDTH
// cycles, with the carry held in a flip-flop. The WIDTH-bit sum and the
// carry-out are then presented together with a one-cycle done pulse.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   req0/req1        request; held with operands until the matching ack
//   a0,b0 / a1,b1    WIDTH-bit operands
//   cin0/cin1        carry-in
//   ack0/ack1        combinational; operands captured at this clock edge
//   busy             high from the cycle after capture through the done cycle
//   done             one-cycle pulse; sum/cout/owner valid
//   sum, cout        result, held until the next done or reset
//   owner            requester whose result is on sum/cout
//------------------------------------------------------------------------------
module serial_add_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             owner
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;

    logic             grant_any;
    logic             winner;
    logic             ha0_s, ha0_c, ha1_c;
    logic             fa_s, fa_c;

    // Shared full adder: two half adders plus an OR for the carry.
    always_comb begin
        ha0_s = a_q[0] ^ b_q[0];
        ha0_c = a_q[0] & b_q[0];
        fa_s  = ha0_s ^ carry_q;
        ha1_c = ha0_s & carry_q;
        fa_c  = ha0_c | ha1_c;
    end

    // Round-robin: on contention, grant the requester that was not served last.
    always_comb begin
        grant_any = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_q;
        end else begin
            winner = req1;
        end
    end

    assign ack0 = ~rst && (state_q == IDLE) && grant_any && ~winner;
    assign ack1 = ~rst && (state_q == IDLE) && grant_any &&  winner;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        owner_d = owner_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    a_d     = winner ? a1 : a0;
                    b_d     = winner ? b1 : b0;
                    carry_d = winner ? cin1 : cin0;
                    cnt_d   = '0;
                    last_d  = winner;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                // Accumulator shifts right with each new sum bit entering at
                // the MSB, so the LSB-first bits end up in their final order.
                acc_d            = acc_q >> 1;
                acc_d[WIDTH-1]   = fa_s;
                carry_d          = fa_c;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Results are published on the edge that enters DONE.
                    sum_d   = acc_d;
                    cout_d  = fa_c;
                    owner_d = last_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign owner = owner_q;

endmodule
